// File: rtl/bus_mem_responder.sv
// Memory-side responder for the cache bus: stores 64-byte lines and serves line reads
// critical-word-first as BEATS data beats, and accepts line writes beat by beat.
module bus_mem_responder #(
  parameter int unsigned      DATA_W    = 64,
  parameter int unsigned      TAG_W     = 13,
  parameter int unsigned      BEATS     = 8,
  parameter int unsigned      LINES     = 256,
  parameter int unsigned      LATENCY   = 4,
  parameter logic [TAG_W-1:0] TAG_READ  = TAG_W'(13'h1100),
  parameter logic [TAG_W-1:0] TAG_WRITE = TAG_W'(13'h0100)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_reqcyc,
  input  logic [DATA_W-1:0] bus_req,
  input  logic [TAG_W-1:0]  bus_reqtag,
  output logic              bus_reqack,
  output logic              bus_respcyc,
  output logic [DATA_W-1:0] bus_resp,
  output logic [TAG_W-1:0]  bus_resptag,
  input  logic              bus_respack
);

  localparam int unsigned BW   = $clog2(BEATS);
  localparam int unsigned LW   = $clog2(LINES);
  localparam int unsigned MW   = LW + BW;
  localparam int unsigned LATW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StWdata, StWait, StRdata} state_e;

  state_e            r_state, w_state_nxt;
  logic [LW-1:0]     r_line, w_line_nxt;
  logic [BW-1:0]     r_word0, w_word0_nxt;
  logic [TAG_W-1:0]  r_tag, w_tag_nxt;
  logic [BW-1:0]     r_beat, w_beat_nxt;
  logic [LATW-1:0]   r_lat, w_lat_nxt;
  logic              r_reqack, w_reqack_nxt;
  logic              w_mem_we;
  logic [BW-1:0]     w_word;
  logic [MW-1:0]     w_mem_idx;
  logic [DATA_W-1:0] w_rd_data;

  // Backing storage; deliberately not reset so a reset mid-write keeps beats already written.
  logic [DATA_W-1:0] r_mem [LINES*BEATS];

  // Word index wraps within the line (critical-word-first), relying on BEATS being a power of 2.
  assign w_word     = r_word0 + r_beat;
  assign w_mem_idx  = {r_line, w_word};
  assign w_rd_data  = r_mem[w_mem_idx];
  assign bus_reqack = r_reqack;

  // State and control registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_line   <= '0;
      r_word0  <= '0;
      r_tag    <= '0;
      r_beat   <= '0;
      r_lat    <= '0;
      r_reqack <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_line   <= w_line_nxt;
      r_word0  <= w_word0_nxt;
      r_tag    <= w_tag_nxt;
      r_beat   <= w_beat_nxt;
      r_lat    <= w_lat_nxt;
      r_reqack <= w_reqack_nxt;
    end
  end

  // Storage write port, fed by the WDATA state.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= bus_req;
    end
  end

  // Next-state logic and response outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_line_nxt   = r_line;
    w_word0_nxt  = r_word0;
    w_tag_nxt    = r_tag;
    w_beat_nxt   = r_beat;
    w_lat_nxt    = r_lat;
    w_reqack_nxt = 1'b0;
    w_mem_we     = 1'b0;
    bus_respcyc  = 1'b0;
    bus_resp     = '0;
    bus_resptag  = '0;

    unique case (r_state)
      StIdle: begin
        // A beat whose ack is currently visible must not be sampled a second time.
        if (bus_reqcyc && !r_reqack) begin
          w_line_nxt   = bus_req[6 +: LW];
          w_word0_nxt  = bus_req[3 +: BW];
          w_tag_nxt    = bus_reqtag;
          w_reqack_nxt = 1'b1;
          w_beat_nxt   = '0;
          w_lat_nxt    = '0;
          if (bus_reqtag == TAG_WRITE) begin
            w_state_nxt = StWdata;
          end else if (bus_reqtag == TAG_READ) begin
            w_state_nxt = StWait;
          end
        end
      end

      StWdata: begin
        if (bus_reqcyc && !r_reqack) begin
          w_mem_we     = 1'b1;
          w_reqack_nxt = 1'b1;
          if (r_beat == BW'(BEATS - 1)) begin
            w_beat_nxt  = '0;
            w_state_nxt = StIdle;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end

      StWait: begin
        if (r_lat == LATW'(LATENCY - 1)) begin
          w_beat_nxt  = '0;
          w_state_nxt = StRdata;
        end else begin
          w_lat_nxt = r_lat + LATW'(1);
        end
      end

      StRdata: begin
        bus_respcyc = 1'b1;
        bus_resp    = w_rd_data;
        bus_resptag = r_tag;
        if (bus_respack) begin
          if (r_beat == BW'(BEATS - 1)) begin
            w_beat_nxt  = '0;
            w_state_nxt = StIdle;
          end else begin
            w_beat_nxt = r_beat + BW'(1);
          end
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder against a flat line-memory reference model.
module tb_bus_mem_responder;

  localparam int          LATENCY   = 4;
  localparam logic [12:0] TAG_READ  = 13'h1100;
  localparam logic [12:0] TAG_WRITE = 13'h0100;
  localparam logic [12:0] TAG_BAD   = 13'h0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int tests = 0;
  int fails = 0;

  // Reference storage: 256 lines x 8 words, indexed line*8+word.
  logic [63:0] model [2048];
  logic [63:0] wdata [8];
  int          written_lines[$];

  always #5 clk = ~clk;

  bus_mem_responder #(
    .DATA_W   (64),
    .TAG_W    (13),
    .BEATS    (8),
    .LINES    (256),
    .LATENCY  (LATENCY),
    .TAG_READ (TAG_READ),
    .TAG_WRITE(TAG_WRITE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  function automatic int line_of(input logic [63:0] a);
    return int'((a >> 6) % 64'd256);
  endfunction

  // Beat i of a read at byte address a: word ((a/8)+i) mod 8 of the addressed line.
  function automatic logic [63:0] exp_beat(input logic [63:0] a, input int i);
    int w;
    w = int'(((a >> 3) + 64'(i)) % 64'd8);
    return model[line_of(a) * 8 + w];
  endfunction

  task automatic wait_ack(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_reqack !== 1'b1 && n < 20);
    tests++;
    if (bus_reqack !== 1'b1) begin
      fails++;
      $display("FAIL %s: reqack=%b after %0d cycles, required 1", nm, bus_reqack, n);
    end
  endtask

  task automatic bus_write(input logic [63:0] addr);
    int n;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = TAG_WRITE;
    wait_ack("wr_addr_ack", n);
    for (int i = 0; i < 8; i++) begin
      bus_req = wdata[i];
      @(negedge clk);
      tests++;
      if (bus_reqack !== 1'b0) begin
        fails++;
        $display("FAIL wr_ack_pulse beat %0d: reqack=%b, required 0", i, bus_reqack);
      end
      wait_ack("wr_data_ack", n);
    end
    bus_reqcyc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      model[line_of(addr) * 8 + int'(((addr >> 3) + 64'(i)) % 64'd8)] = wdata[i];
    end
    if (!(line_of(addr) inside {written_lines})) written_lines.push_back(line_of(addr));
  endtask

  // Receive a full line; optionally abort with reset at a beat, or raise a pending request.
  task automatic recv_line(input logic [63:0] addr, input int mind, input int maxd,
                           input int abort_at, input bit pend, input logic [63:0] pend_addr);
    logic [63:0] exp;
    int          stray_acks = 0;
    int          n;
    int          d;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      while (bus_respcyc !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
        if (pend && bus_reqack === 1'b1) stray_acks++;
      end
      tests++;
      if (bus_respcyc !== 1'b1) begin
        fails++;
        $display("FAIL rd_beat_timeout beat %0d: respcyc=%b, required 1", b, bus_respcyc);
        return;
      end
      exp = exp_beat(addr, b);
      if (b == abort_at) begin
        reset = 1'b1;
        #1;
        tests++;
        if (bus_respcyc !== 1'b0 || bus_resp !== 64'd0 || bus_resptag !== 13'd0 ||
            bus_reqack !== 1'b0) begin
          fails++;
          $display("FAIL async_reset: respcyc=%b resp=%h tag=%h ack=%b, required all 0",
                   bus_respcyc, bus_resp, bus_resptag, bus_reqack);
        end
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      tests++;
      if (bus_resp !== exp || bus_resptag !== TAG_READ) begin
        fails++;
        $display("FAIL rd_data addr %h beat %0d: got %h tag %h, required %h tag %h",
                 addr, b, bus_resp, bus_resptag, exp, TAG_READ);
      end
      if (pend && b == 2) begin
        bus_reqcyc = 1'b1;
        bus_req    = pend_addr;
        bus_reqtag = TAG_READ;
      end
      d = int'($urandom_range(maxd, mind));
      for (int k = 0; k < d; k++) begin
        @(negedge clk);
        if (pend && bus_reqack === 1'b1) stray_acks++;
        tests++;
        if (bus_respcyc !== 1'b1 || bus_resp !== exp) begin
          fails++;
          $display("FAIL rd_hold beat %0d: respcyc=%b resp=%h, required 1 %h",
                   b, bus_respcyc, bus_resp, exp);
        end
      end
      bus_respack = 1'b1;
      @(negedge clk);
      bus_respack = 1'b0;
      if (pend && bus_reqack === 1'b1) stray_acks++;
    end
    tests++;
    if (bus_respcyc !== 1'b0) begin
      fails++;
      $display("FAIL rd_end: respcyc=%b after last beat, required 0", bus_respcyc);
    end
    if (pend) begin
      tests++;
      if (stray_acks !== 0) begin
        fails++;
        $display("FAIL req_held_off: %0d acks during read, required 0", stray_acks);
      end
    end
  endtask

  task automatic read_line(input logic [63:0] addr, input int mind, input int maxd,
                           input bit timing);
    int n;
    int m;
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = TAG_READ;
    wait_ack("rd_ack", n);
    bus_reqcyc = 1'b0;
    if (timing) begin
      tests++;
      if (n !== 1) begin
        fails++;
        $display("FAIL rd_ack_latency: %0d cycles, required 1", n);
      end
    end
    m = 0;
    // Random respack while no beat is offered must be ignored.
    while (bus_respcyc !== 1'b1 && m < 40) begin
      bus_respack = 1'($urandom % 2);
      @(negedge clk);
      m++;
    end
    bus_respack = 1'b0;
    if (timing) begin
      tests++;
      if (m !== LATENCY) begin
        fails++;
        $display("FAIL rd_first_beat_latency: %0d cycles after ack, required %0d", m, LATENCY);
      end
    end
    recv_line(addr, mind, maxd, -1, 1'b0, 64'd0);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== 64'd0 ||
        bus_resptag !== 13'd0) begin
      fails++;
      $display("FAIL reset_state: ack=%b respcyc=%b resp=%h tag=%h, required all 0",
               bus_reqack, bus_respcyc, bus_resp, bus_resptag);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_basic;
    for (int i = 0; i < 8; i++) wdata[i] = 64'h1000 + 64'(i);
    @(negedge clk);
    bus_write(64'h40);
    read_line(64'h40, 0, 0, 1'b1);
  endtask

  task automatic test_read_wrap;
    read_line(64'h68, 0, 1, 1'b1);
  endtask

  task automatic test_write_read;
    for (int i = 0; i < 8; i++) wdata[i] = 64'hA0 + 64'(i);
    @(negedge clk);
    bus_write(64'h80);
    read_line(64'h80, 0, 0, 1'b1);
  endtask

  task automatic test_slow_respack;
    read_line(64'h40, 3, 3, 1'b0);
  endtask

  task automatic test_req_during_read;
    int n;
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h58;
    bus_reqtag = TAG_READ;
    wait_ack("rd_ack", n);
    bus_reqcyc = 1'b0;
    recv_line(64'h58, 0, 1, -1, 1'b1, 64'h98);
    wait_ack("pending_req_ack", n);
    bus_reqcyc = 1'b0;
    recv_line(64'h98, 0, 0, -1, 1'b0, 64'd0);
  endtask

  task automatic test_bad_tag;
    int n;
    int spurious = 0;
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h40;
    bus_reqtag = TAG_BAD;
    wait_ack("bad_tag_ack", n);
    bus_reqcyc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus_respcyc !== 1'b0 || bus_reqack !== 1'b0) spurious++;
    end
    tests++;
    if (spurious !== 0) begin
      fails++;
      $display("FAIL bad_tag_dropped: %0d active cycles, required 0", spurious);
    end
    read_line(64'h40, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = 64'h40;
    bus_reqtag = TAG_READ;
    wait_ack("rd_ack", n);
    bus_reqcyc = 1'b0;
    recv_line(64'h40, 0, 0, 3, 1'b0, 64'd0);
    read_line(64'h40, 0, 0, 1'b1);
  endtask

  task automatic test_back_to_back;
    int n;
    for (int i = 0; i < 8; i++) wdata[i] = {$urandom(), $urandom()};
    @(negedge clk);
    bus_write(64'h3000_0000_0000_0EC8);
    // Read of the same line issued immediately after the last write ack.
    bus_reqcyc = 1'b1;
    bus_req    = 64'hEC0;
    bus_reqtag = TAG_READ;
    wait_ack("b2b_rd_ack", n);
    bus_reqcyc = 1'b0;
    recv_line(64'hEC0, 0, 0, -1, 1'b0, 64'd0);
  endtask

  task automatic test_random;
    logic [63:0] a;
    for (int op = 0; op < 24; op++) begin
      a = {$urandom(), $urandom()};
      if (($urandom % 2) == 0) begin
        for (int i = 0; i < 8; i++) wdata[i] = {$urandom(), $urandom()};
        @(negedge clk);
        bus_write(a);
      end else begin
        a[13:6] = 8'(written_lines[$urandom_range(written_lines.size() - 1, 0)]);
        read_line(a, 0, 2, 1'b1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    test_reset();
    test_read_basic();
    test_read_wrap();
    test_write_read();
    test_slow_respack();
    test_req_during_read();
    test_bad_tag();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
